multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/regfile_pkg.sv | 6 +
 rtl/regfile_scoreboard.sv | 47 ++++
 rtl/multiport_regfile.sv | 53 +++++
 tb/tb_multiport_regfile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and constants for the multiport register file.
package regfile_pkg;
  localparam int DEF_XLEN  = 64;
  localparam int DEF_NREGS = 32;
  localparam int ZERO_REG  = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, registered busy count and read-port busy flags.
// REGFILE_BYPASS_EN: a same-cycle write to rsN hides its busy bit unless that register is reissued.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREGS = DEF_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          issue_en,
  input  logic [AW-1:0] issue_rd,
  output logic          busy1,
  output logic          busy2,
  output logic [AW:0]   busy_cnt
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_set, do_clr, inc, dec;
  always_comb begin
    do_set = issue_en && issue_rd != AW'(ZERO_REG);
    do_clr = wr_en && wr_addr != AW'(ZERO_REG);
    inc = do_set && !busy_q[issue_rd];
    dec = do_clr && busy_q[wr_addr] && !(do_set && issue_rd == wr_addr);
    for (int i = 0; i < NREGS; i++)
      busy_d[i] = i != ZERO_REG && ((do_set && issue_rd == AW'(i)) || (busy_q[i] && !(do_clr && wr_addr == AW'(i))));
    cnt_d = cnt_q + (AW+1)'(inc) - (AW+1)'(dec);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy_q <= '0;
      cnt_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q <= cnt_d;
    end
`ifdef REGFILE_BYPASS_EN
  assign busy1 = (reset && do_clr && wr_addr == rs1) ? do_set && issue_rd == rs1 : busy_q[rs1];
  assign busy2 = (reset && do_clr && wr_addr == rs2) ? do_set && issue_rd == rs2 : busy_q[rs2];
`else
  assign busy1 = busy_q[rs1];
  assign busy2 = busy_q[rs2];
`endif
  assign busy_cnt = cnt_q;
endmodule

// File: rtl/multiport_regfile.sv
// multiport_regfile: two combinational read ports, one write port, hardwired zero register, issue scoreboard.
// REGFILE_BYPASS_EN: forward same-cycle write data to any read port addressing the written register.
module multiport_regfile import regfile_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  localparam int AW = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     busy_cnt
);
  logic [XLEN-1:0] regs_q [NREGS];
  logic wr_hit;
  assign wr_hit = wr_en && wr_addr != AW'(ZERO_REG);
  // register 0 is reset to zero and never written, so it always reads zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[wr_addr] <= wr_data;
    end
`ifdef REGFILE_BYPASS_EN
  assign rd_data1 = (reset && wr_hit && wr_addr == rs1) ? wr_data : regs_q[rs1];
  assign rd_data2 = (reset && wr_hit && wr_addr == rs2) ? wr_data : regs_q[rs2];
`else
  assign rd_data1 = regs_q[rs1];
  assign rd_data2 = regs_q[rs2];
`endif
  regfile_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk(clk),
    .reset(reset),
    .rs1(rs1),
    .rs2(rs2),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .issue_en(issue_en),
    .issue_rd(issue_rd),
    .busy1(busy1),
    .busy2(busy2),
    .busy_cnt(busy_cnt)
  );
endmodule

// File: tb/tb_multiport_regfile.sv
// tb_multiport_regfile: scoreboard-queue bench for multiport_regfile; follows REGFILE_BYPASS_EN when defined.
module tb_multiport_regfile;
  localparam int XLEN = 64;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, wr_addr = '0, issue_rd = '0;
  logic [XLEN-1:0] wr_data = '0, rd_data1, rd_data2;
  logic wr_en = 1'b0, issue_en = 1'b0, busy1, busy2;
  logic [AW:0] busy_cnt;
  always #5 clk = ~clk;
  multiport_regfile #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .busy1(busy1), .busy2(busy2), .busy_cnt(busy_cnt)
  );
  typedef struct packed {
    logic [XLEN-1:0] d1;
    logic [XLEN-1:0] d2;
    logic b1;
    logic b2;
    logic [AW:0] cnt;
  } obs_t;
  typedef struct {
    bit rst, we, ie;
    logic [AW-1:0] wa, ir, r1, r2;
    logic [XLEN-1:0] wd;
    obs_t e;
  } step_t;
  obs_t act, e;
  assign act = {rd_data1, rd_data2, busy1, busy2, busy_cnt};
  obs_t exp_q[$];
  step_t q[$];
  int checks = 0, failures = 0;
  logic [XLEN-1:0] m_regs [NREGS];
  logic [NREGS-1:0] m_busy;

  function automatic step_t st(bit rst, bit we, int wa, logic [XLEN-1:0] wd, bit ie, int ir, int r1, int r2,
                               logic [XLEN-1:0] d1, logic [XLEN-1:0] d2, bit b1, bit b2, int cnt);
    step_t s;
    s.rst = rst; s.we = we; s.wa = AW'(wa); s.wd = wd; s.ie = ie; s.ir = AW'(ir);
    s.r1 = AW'(r1); s.r2 = AW'(r2);
    s.e = '{d1: d1, d2: d2, b1: b1, b2: b2, cnt: (AW+1)'(cnt)};
    return s;
  endfunction

  task automatic apply(step_t s);
    reset = s.rst; wr_en = s.we; wr_addr = s.wa; wr_data = s.wd;
    issue_en = s.ie; issue_rd = s.ir; rs1 = s.r1; rs2 = s.r2;
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int n = 0;
    bit h1 = BYP && wr_en && wr_addr != 0 && wr_addr == rs1;
    bit h2 = BYP && wr_en && wr_addr != 0 && wr_addr == rs2;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    o.d1 = rs1 == 0 ? '0 : h1 ? wr_data : m_regs[rs1];
    o.d2 = rs2 == 0 ? '0 : h2 ? wr_data : m_regs[rs2];
    o.b1 = rs1 == 0 ? 1'b0 : h1 ? (issue_en && issue_rd == rs1) : m_busy[rs1];
    o.b2 = rs2 == 0 ? 1'b0 : h2 ? (issue_en && issue_rd == rs2) : m_busy[rs2];
    o.cnt = (AW+1)'(n);
    return o;
  endfunction

  task automatic model_commit();
    if (wr_en && wr_addr != 0) begin
      m_regs[wr_addr] = wr_data;
      m_busy[wr_addr] = 1'b0;
    end
    if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
  endtask

  task automatic test_reset();
    q.delete();
    q.push_back(st(0, 1, 5, 'hAAAA, 1, 5, 5, 5, 0, 0, 0, 0, 0));
    q.push_back(st(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL reset[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    q.delete();
    q.push_back(st(1, 1, 5, 64'hDEAD_BEEF, 0, 0, 5, 0, BYP ? 64'hDEAD_BEEF : 0, 0, 0, 0, 0));
    q.push_back(st(1, 1, 0, 7, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 5, 0, 64'hDEAD_BEEF, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 5, 5, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL write_read[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_scoreboard();
    q.delete();
    q.push_back(st(1, 0, 0, 0, 1, 3, 3, 4, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 1, 4, 3, 4, 0, 0, 1, 0, 1));
    q.push_back(st(1, 0, 0, 0, 1, 4, 3, 4, 0, 0, 1, 1, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 3, 4, 0, 0, 1, 1, 2));
    q.push_back(st(1, 1, 4, 'h44, 0, 0, 3, 4, 0, BYP ? 'h44 : 0, 1, !BYP, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 3, 4, 0, 'h44, 1, 0, 1));
    q.push_back(st(1, 1, 7, 'h77, 0, 0, 7, 3, BYP ? 'h77 : 0, 0, 0, 1, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 7, 3, 'h77, 0, 0, 1, 1));
    q.push_back(st(1, 1, 0, 'hFF, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL scoreboard[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_collision();
    q.delete();
    q.push_back(st(1, 0, 0, 0, 1, 9, 9, 3, 0, 0, 0, 1, 1));
    q.push_back(st(1, 1, 9, 'h99, 1, 9, 9, 3, BYP ? 'h99 : 0, 0, 1, 1, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 9, 3, 'h99, 0, 1, 1, 2));
    q.push_back(st(1, 1, 3, 'h33, 1, 10, 10, 3, 0, BYP ? 'h33 : 0, 0, !BYP, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 10, 3, 0, 'h33, 1, 0, 2));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL collision[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bypass();
    q.delete();
    q.push_back(st(1, 1, 6, 'h66, 0, 0, 1, 2, 0, 0, 0, 0, 2));
    q.push_back(st(1, 1, 6, 'h55, 0, 0, 6, 6, BYP ? 'h55 : 'h66, BYP ? 'h55 : 'h66, 0, 0, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 6, 9, 'h55, 'h99, 0, 1, 2));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL bypass[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    q.push_back(st(1, 0, 0, 0, 1, 11, 9, 5, 'h99, 64'hDEAD_BEEF, 1, 0, 2));
    q.push_back(st(1, 0, 0, 0, 0, 0, 9, 10, 'h99, 0, 1, 1, 3));
    q.push_back(st(0, 0, 0, 0, 0, 0, 9, 10, 0, 0, 0, 0, 0));
    q.push_back(st(1, 0, 0, 0, 0, 0, 9, 5, 0, 0, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    q.delete();
    for (int i = 1; i < NREGS; i++) q.push_back(st(1, 0, 0, 0, 1, i, i, 0, 0, 0, 0, 0, i - 1));
    q.push_back(st(1, 0, 0, 0, 0, 0, NREGS - 1, 0, 0, 0, 1, 0, NREGS - 1));
    for (int i = 1; i < NREGS; i++)
      q.push_back(st(1, 1, i, XLEN'(i * 3 + 1), 0, 0, i, 0, BYP ? XLEN'(i * 3 + 1) : 0, 0, !BYP, 0, NREGS - i));
    q.push_back(st(1, 0, 0, 0, 0, 0, NREGS - 1, 1, XLEN'(NREGS * 3 - 2), 4, 0, 0, 0));
    foreach (q[i]) begin
      apply(q[i]); exp_q.push_back(q[i].e); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL fill[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", i,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? NREGS - 1 : 7));
  endfunction

  task automatic test_random();
    apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    m_busy = '0;
    for (int n = 0; n < 400; n++) begin
      wr_en = 1'($urandom_range(0, 1)); wr_addr = rnd_addr(); wr_data = XLEN'({$urandom(), $urandom()});
      issue_en = 1'($urandom_range(0, 1)); issue_rd = $urandom_range(0, 2) == 0 ? wr_addr : rnd_addr();
      rs1 = $urandom_range(0, 1) == 0 ? wr_addr : rnd_addr();
      rs2 = $urandom_range(0, 3) == 0 ? rs1 : rnd_addr();
      exp_q.push_back(model_out()); #2;
      e = exp_q.pop_front(); checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL random[%0d]: got %h/%h b%b%b cnt=%0d want %h/%h b%b%b cnt=%0d", n,
                 act.d1, act.d2, act.b1, act.b2, act.cnt, e.d1, e.d2, e.b1, e.b2, e.cnt);
      end
      @(posedge clk);
      model_commit();
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_reset_mid();
    test_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
